// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl_if
// Brief    : Divide-ratio configuration handshake (valid/ready plus error flag)
// Revision : 1.0
// ============================================================================
interface clk_div_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Run-time clock divider with glitch-free ratio and start/stop updates
// Revision : 1.0
// ============================================================================
module clk_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  wire logic             clk_in,
    input  wire logic             rstn,
    input  wire logic             en,
    clk_div_ctrl_if.slave         cfg,
    output logic                  clk_out,
    output logic                  tick,
    output logic                  active,
    output logic [DIV_W-1:0]      cur_div
);

    localparam logic [DIV_W-1:0] c_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_TWO     = DIV_W'(2);
    localparam logic [DIV_W-1:0] c_DEF_DIV = DIV_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] w_high_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic             r_cfg_err;
    logic             r_clk_out;
    logic             r_active;
    logic             w_accept;
    logic             w_legal;
    logic             w_wrap;

    assign w_wrap   = (r_state != ST_IDLE) && (r_cnt == (r_div - c_ONE));
    assign w_accept = cfg.cfg_valid && !r_pend;
    assign w_legal  = (cfg.cfg_div >= c_TWO);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_pend_nxt  = r_pend;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (r_pend) begin
                    w_div_nxt  = r_pend_div;
                    w_pend_nxt = 1'b0;
                end
                if (en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                end else if (w_wrap) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A new ratio only ever takes effect where a period begins.
        if (r_state != ST_IDLE) begin
            if (w_wrap) begin
                w_cnt_nxt = '0;
                if (r_pend) begin
                    w_div_nxt  = r_pend_div;
                    w_pend_nxt = 1'b0;
                end
            end else begin
                w_cnt_nxt = r_cnt + c_ONE;
            end
        end

        if (w_accept && w_legal) begin
            w_pend_nxt = 1'b1;
        end

        w_high_nxt = w_div_nxt - (w_div_nxt >> 1);
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_div      <= c_DEF_DIV;
            r_pend     <= 1'b0;
            r_pend_div <= c_DEF_DIV;
            r_cfg_err  <= 1'b0;
            r_clk_out  <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_pend    <= w_pend_nxt;
            r_cfg_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_pend_div <= cfg.cfg_div;
            end
            // Output level is computed from next-cycle state so it stays a pure register.
            r_clk_out <= (w_state_nxt != ST_IDLE) && (w_cnt_nxt < w_high_nxt);
            r_active  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign cfg.cfg_ready = !r_pend;
    assign cfg.cfg_err   = r_cfg_err;
    assign clk_out       = r_clk_out;
    assign tick          = w_wrap;
    assign active        = r_active;
    assign cur_div       = r_div;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Brief    : Self-checking bench for clk_div_ctrl against a period-level model
// Revision : 1.0
// ============================================================================
module tb_clk_div_ctrl;

    logic       clk_in;
    logic       rstn;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       clk_out;
    logic       tick;
    logic       active;
    logic [7:0] cur_div;

    int total;
    int bad;

    clk_div_ctrl_if #(.DIV_W(8)) cfg_bus ();
    assign cfg_bus.cfg_valid = cfg_valid;
    assign cfg_bus.cfg_div   = cfg_div;

    clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(8)) dut (
        .clk_in  (clk_in),
        .rstn    (rstn),
        .en      (en),
        .cfg     (cfg_bus),
        .clk_out (clk_out),
        .tick    (tick),
        .active  (active),
        .cur_div (cur_div)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // {clk_out, tick, active, cfg_ready, cfg_err, cur_div}
    wire logic [12:0] dut_vec = {clk_out, tick, active, cfg_bus.cfg_ready, cfg_bus.cfg_err, cur_div};
    localparam logic [12:0] c_RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd8};

    // Reference model: running flag, stop request, phase inside the period, ratios.
    bit m_run;
    bit m_stop;
    int m_ph;
    int m_D;
    bit m_pend;
    int m_pd;
    bit m_err;

    function automatic void model_reset();
        m_run = 0; m_stop = 0; m_ph = 0; m_D = 8; m_pend = 0; m_pd = 8; m_err = 0;
    endfunction

    function automatic logic [12:0] model_vec();
        logic [7:0] d8;
        d8 = m_D[7:0];
        return {m_run && (m_ph < m_D - m_D / 2), m_run && (m_ph == m_D - 1),
                m_run, !m_pend, m_err, d8};
    endfunction

    function automatic void model_edge();
        bit acc;
        bit wrap;
        bit was_stop;
        int dval;
        acc      = cfg_valid && !m_pend;
        dval     = int'(cfg_div);
        wrap     = m_run && (m_ph == m_D - 1);
        was_stop = m_stop;
        if (!m_run) begin
            if (m_pend) begin m_D = m_pd; m_pend = 0; end
            m_ph = 0;
            if (en) begin m_run = 1; m_stop = 0; end
        end else begin
            if (wrap) begin
                m_ph = 0;
                if (m_pend) begin m_D = m_pd; m_pend = 0; end
            end else begin
                m_ph = m_ph + 1;
            end
            if (wrap && was_stop && !en) m_run = 0;
            else m_stop = !en;
        end
        m_err = acc && (dval < 2);
        if (acc && dval >= 2) begin m_pend = 1; m_pd = dval; end
    endfunction

    task automatic advance();
        @(posedge clk_in);
        if (!rstn) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic do_reset();
        en = 0; cfg_valid = 0; cfg_div = 0;
        rstn = 0;
        advance();
        rstn = 1;
    endtask

    task automatic drain();
        int n;
        en = 0;
        n = 0;
        while (active && n < 300) begin
            advance();
            n++;
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL drain_vec: got %h want %h", dut_vec, model_vec());
            end
        end
        total++;
        if (active !== 1'b0) begin
            bad++; $display("FAIL drain_timeout: got active=%b want 0", active);
        end
    endtask

    task automatic test_reset();
        en = 0; cfg_valid = 0; cfg_div = 0;
        rstn = 0;
        #3;
        model_reset();
        advance();
        advance();
        total++;
        if (dut_vec !== c_RST_VEC) begin
            bad++; $display("FAIL reset_vec: got %h want %h", dut_vec, c_RST_VEC);
        end
        rstn = 1;
        advance();
        total++;
        if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL reset_idle: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_default_run();
        int ticks;
        int highs;
        ticks = 0; highs = 0;
        en = 1;
        for (int i = 0; i < 24; i++) begin
            advance();
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL run8_vec: got %h want %h", dut_vec, model_vec());
            end
            ticks += int'(tick);
            highs += int'(clk_out);
        end
        total++;
        if (ticks != 3) begin bad++; $display("FAIL run8_ticks: got %0d want 3", ticks); end
        total++;
        if (highs != 12) begin bad++; $display("FAIL run8_highs: got %0d want 12", highs); end
        drain();
    endtask

    task automatic test_idle_cfg();
        int ticks;
        int highs;
        do_reset();
        cfg_valid = 1; cfg_div = 8'd5;
        advance();
        cfg_valid = 0;
        advance();
        total++;
        if (cur_div !== 8'd5 || cfg_bus.cfg_ready !== 1'b1) begin
            bad++; $display("FAIL idle_cfg_apply: got div=%0d rdy=%b want 5 1", cur_div, cfg_bus.cfg_ready);
        end
        ticks = 0; highs = 0;
        en = 1;
        for (int i = 0; i < 20; i++) begin
            advance();
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL run5_vec: got %h want %h", dut_vec, model_vec());
            end
            ticks += int'(tick);
            highs += int'(clk_out);
        end
        total++;
        if (ticks != 4 || highs != 12) begin
            bad++; $display("FAIL run5_shape: got ticks=%0d highs=%0d want 4 12", ticks, highs);
        end
        drain();
    endtask

    task automatic test_midperiod_cfg();
        int first_tick;
        int highs;
        do_reset();
        en = 1;
        repeat (3) advance();
        cfg_valid = 1; cfg_div = 8'd4;
        advance();
        cfg_valid = 0;
        first_tick = -1; highs = 0;
        for (int i = 0; i < 12; i++) begin
            advance();
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL mid_vec: got %h want %h", dut_vec, model_vec());
            end
            if (tick && first_tick < 0) first_tick = i;
            if (i <= 3) begin
                total++;
                if (cfg_bus.cfg_ready !== 1'b0) begin
                    bad++; $display("FAIL mid_ready_low: got %b want 0", cfg_bus.cfg_ready);
                end
            end
            if (i == 4) begin
                total++;
                if (cur_div !== 8'd4 || cfg_bus.cfg_ready !== 1'b1) begin
                    bad++; $display("FAIL mid_wrap: got div=%0d rdy=%b want 4 1", cur_div, cfg_bus.cfg_ready);
                end
            end
            if (i >= 4) highs += int'(clk_out);
        end
        total++;
        if (first_tick != 3) begin bad++; $display("FAIL mid_period_len: got %0d want 3", first_tick); end
        total++;
        if (highs != 4) begin bad++; $display("FAIL mid_new_highs: got %0d want 4", highs); end
        drain();
    endtask

    task automatic test_illegal_cfg();
        logic [7:0] vals [2];
        vals[0] = 8'd1; vals[1] = 8'd0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            cfg_valid = 1; cfg_div = vals[k];
            advance();
            cfg_valid = 0;
            total++;
            if (cfg_bus.cfg_err !== 1'b1 || cur_div !== 8'd8 || cfg_bus.cfg_ready !== 1'b1) begin
                bad++; $display("FAIL illegal_pulse: got err=%b div=%0d rdy=%b want 1 8 1",
                                cfg_bus.cfg_err, cur_div, cfg_bus.cfg_ready);
            end
            advance();
            total++;
            if (dut_vec !== model_vec() || cfg_bus.cfg_err !== 1'b0) begin
                bad++; $display("FAIL illegal_one_cycle: got %h want %h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_stop();
        int n;
        int ticks;
        do_reset();
        en = 1;
        repeat (4) advance();
        en = 0;
        n = 0; ticks = 0;
        while (n < 40) begin
            advance();
            n++;
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL stop_vec: got %h want %h", dut_vec, model_vec());
            end
            ticks += int'(tick);
            if (!active) break;
        end
        total++;
        if (n != 5 || ticks != 1 || clk_out !== 1'b0) begin
            bad++; $display("FAIL stop_finish: got n=%0d ticks=%0d clk=%b want 5 1 0", n, ticks, clk_out);
        end
    endtask

    task automatic test_restart();
        int ticks;
        int highs;
        int gaps;
        do_reset();
        en = 1;
        repeat (4) advance();
        en = 0;
        repeat (2) advance();
        en = 1;
        ticks = 0; highs = 0; gaps = 0;
        for (int i = 0; i < 16; i++) begin
            advance();
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL restart_vec: got %h want %h", dut_vec, model_vec());
            end
            ticks += int'(tick);
            highs += int'(clk_out);
            if (!active) gaps++;
        end
        total++;
        if (ticks != 2 || highs != 8 || gaps != 0) begin
            bad++; $display("FAIL restart_shape: got ticks=%0d highs=%0d gaps=%0d want 2 8 0", ticks, highs, gaps);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1;
        repeat (3) advance();
        cfg_valid = 1; cfg_div = 8'd6;
        advance();
        cfg_valid = 0;
        repeat (2) advance();
        total++;
        if (cfg_bus.cfg_ready !== 1'b0 || active !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: got rdy=%b act=%b want 0 1", cfg_bus.cfg_ready, active);
        end
        #2;
        rstn = 0;
        #1;
        model_reset();
        total++;
        if (dut_vec !== c_RST_VEC) begin
            bad++; $display("FAIL rstmid_async: got %h want %h", dut_vec, c_RST_VEC);
        end
        advance();
        rstn = 1;
        en = 0;
        advance();
        total++;
        if (dut_vec !== model_vec() || cur_div !== 8'd8 || cfg_bus.cfg_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_after: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        en = 1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) en = !en;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = 8'($urandom_range(0, 12));
            advance();
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL random_vec: cycle %0d got %h want %h", i, dut_vec, model_vec());
            end
        end
        cfg_valid = 0;
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn = 0; en = 0; cfg_valid = 0; cfg_div = 0;
        model_reset();
        test_reset();
        test_default_run();
        test_idle_cfg();
        test_midperiod_cfg();
        test_illegal_cfg();
        test_stop();
        test_restart();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
